// File: rtl/reg_bank_pkg.sv
// Shared types and default sizes for the register bank read path.
package reg_bank_pkg;

  // Default geometry of the MIPS register bank.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_WIDTH-1:0] word_t;

  // One dual-port read response as seen by the decode stage.
  typedef struct packed {
    word_t a;
    word_t b;
    logic  err;
  } rd_rsp_t;

  // Occupancy of the output register (OUT) and the skid register (SKID).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    BOTH  = 2'd2
  } rdr_state_t;

endpackage : reg_bank_pkg

// File: rtl/rb_read_mux.sv
// Single read port: selects one register from the flattened bank outputs,
// forcing register 0 to zero, flagging out-of-range addresses and forwarding
// a write that lands on the addressed register in the same cycle.
module rb_read_mux #(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [NREGS*WIDTH-1:0] bank_q_i,
  input  logic [NREGS-1:0]       wr_en_i,
  input  logic [WIDTH-1:0]       wr_d_i,
  input  logic [AW-1:0]          addr_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   err_o
);

  logic [WIDTH-1:0] words [NREGS];
  logic             in_range;

  // Unflatten the bank so each register can be indexed directly.
  for (genvar gi = 0; gi < NREGS; gi++) begin : g_unpack
    assign words[gi] = bank_q_i[gi*WIDTH +: WIDTH];
  end

  // A fully populated address space can never be out of range, so the
  // compare disappears entirely in that case.
  if (NREGS == (1 << AW)) begin : g_full_space
    assign in_range = 1'b1;
  end else begin : g_partial_space
    assign in_range = ({1'b0, addr_i} < (AW+1)'(NREGS));
  end

  // Priority: hardwired zero, then range error, then bypass, then bank value.
  always_comb begin
    data_o = '0;
    err_o  = ~in_range;
    if (addr_i == '0) begin
      data_o = '0;
    end else if (!in_range) begin
      data_o = '0;
    end else if (wr_en_i[addr_i]) begin
      data_o = wr_d_i;
    end else begin
      data_o = words[addr_i];
    end
  end

endmodule : rb_read_mux

// File: rtl/reg_bank_reader.sv
// Read-side front end of the register bank: accepts dual-address read
// requests, snapshots the read values at accept time and returns them over a
// valid/ready channel with a one-entry skid buffer so req_ready never depends
// combinationally on rsp_ready.
module reg_bank_reader
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = reg_bank_pkg::DEF_WIDTH,
  parameter int NREGS = reg_bank_pkg::DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREGS*WIDTH-1:0] bank_q,
  input  logic [NREGS-1:0]       wr_en,
  input  logic [WIDTH-1:0]       wr_d,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [AW-1:0]          req_addr_a,
  input  logic [AW-1:0]          req_addr_b,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [WIDTH-1:0]       rsp_data_a,
  output logic [WIDTH-1:0]       rsp_data_b,
  output logic                   rsp_err
);

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             err;
  } rsp_t;

  rdr_state_t state_q;
  rsp_t       out_q;
  rsp_t       skid_q;
  rsp_t       rsp_d;

  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic             err_a;
  logic             err_b;
  logic             accept;
  logic             xfer;

  rb_read_mux #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_mux_a (
    .bank_q_i (bank_q),
    .wr_en_i  (wr_en),
    .wr_d_i   (wr_d),
    .addr_i   (req_addr_a),
    .data_o   (data_a),
    .err_o    (err_a)
  );

  rb_read_mux #(
    .WIDTH (WIDTH),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_mux_b (
    .bank_q_i (bank_q),
    .wr_en_i  (wr_en),
    .wr_d_i   (wr_d),
    .addr_i   (req_addr_b),
    .data_o   (data_b),
    .err_o    (err_b)
  );

  // Response as it would be captured if a request is accepted this cycle.
  always_comb begin
    rsp_d     = '0;
    rsp_d.a   = data_a;
    rsp_d.b   = data_b;
    rsp_d.err = err_a | err_b;
  end

  // Ready is a function of state only; reset holds it low.
  assign req_ready = rst && (state_q != BOTH);
  assign rsp_valid = (state_q != EMPTY);
  assign accept    = req_valid && req_ready;
  assign xfer      = rsp_valid && rsp_ready;

  assign rsp_data_a = out_q.a;
  assign rsp_data_b = out_q.b;
  assign rsp_err    = out_q.err;

  // Occupancy FSM: OUT feeds the consumer, SKID absorbs one extra accept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            out_q   <= rsp_d;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (accept && xfer) begin
            out_q <= rsp_d;
          end else if (xfer) begin
            state_q <= EMPTY;
          end else if (accept) begin
            skid_q  <= rsp_d;
            state_q <= BOTH;
          end
        end
        BOTH: begin
          if (xfer) begin
            out_q   <= skid_q;
            state_q <= FULL;
          end
        end
        default: begin
          state_q <= EMPTY;
        end
      endcase
    end
  end

endmodule : reg_bank_reader

// File: tb/tb_reg_bank_reader.sv
// Self-checking bench for reg_bank_reader: a queue-based model of the
// response channel is compared against the DUT every cycle, with literal
// checks pinning the directed scenarios.
module tb_reg_bank_reader;

  localparam int W = 32;
  localparam int N = 32;
  localparam int A = 5;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         err;
  } exp_t;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] bank_q;
  logic [N-1:0]   wr_en;
  logic [W-1:0]   wr_d;
  logic           req_valid;
  logic           req_ready;
  logic [A-1:0]   req_addr_a;
  logic [A-1:0]   req_addr_b;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [W-1:0]   rsp_data_a;
  logic [W-1:0]   rsp_data_b;
  logic           rsp_err;

  logic [W-1:0] bank_mem [N];
  exp_t         mq [$];
  int           checks;
  int           failures;
  bit           started;

  reg_bank_reader dut (
    .clk        (clk),
    .rst        (rst),
    .bank_q     (bank_q),
    .wr_en      (wr_en),
    .wr_d       (wr_d),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr_a (req_addr_a),
    .req_addr_b (req_addr_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data_a (rsp_data_a),
    .rsp_data_b (rsp_data_b),
    .rsp_err    (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present the bench-owned bank contents to the DUT.
  always_comb begin
    bank_q = '0;
    for (int i = 0; i < N; i++) bank_q[i*W +: W] = bank_mem[i];
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Value a read of addr must return this cycle.
  function automatic logic [W-1:0] model_read(input logic [A-1:0] addr);
    if (addr == 0) return '0;
    if (int'(addr) >= N) return '0;
    if (wr_en[addr]) return wr_d;
    return bank_mem[addr];
  endfunction

  // Compare DUT against the model, then advance the model across the next edge.
  task automatic step();
    exp_t e;
    bit   acc;
    bit   xfer;
    @(negedge clk);
    if (started) begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, rst && (mq.size() < 2)});
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) begin
        chk("rsp_data_a", rsp_data_a, mq[0].a);
        chk("rsp_data_b", rsp_data_b, mq[0].b);
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, mq[0].err});
      end
    end
    if (!rst) begin
      mq.delete();
      started = 1'b1;
    end else begin
      acc  = req_valid && (mq.size() < 2);
      xfer = (mq.size() > 0) && rsp_ready;
      if (xfer) begin
        e = mq.pop_front();
        $display("rsp a=%h b=%h err=%0d", e.a, e.b, e.err);
      end
      if (acc) begin
        e.a   = model_read(req_addr_a);
        e.b   = model_read(req_addr_b);
        e.err = (int'(req_addr_a) >= N) || (int'(req_addr_b) >= N);
        mq.push_back(e);
        $display("req a=%0d b=%0d", req_addr_a, req_addr_b);
      end
    end
    @(posedge clk);
    #1;
    // The bank itself updates at the same edge as the bypassed write.
    for (int i = 0; i < N; i++) if (wr_en[i]) bank_mem[i] = wr_d;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    started    = 1'b0;
    for (int i = 0; i < N; i++) bank_mem[i] = 32'h0101_0101 * i;
    bank_mem[5] = 32'hDEAD_BEEF;
    bank_mem[9] = 32'h1234_5678;
    rst        = 1'b0;
    wr_en      = '0;
    wr_d       = '0;
    req_valid  = 1'b1;
    req_addr_a = 5'd3;
    req_addr_b = 5'd4;
    rsp_ready  = 1'b0;

    // 1: reset held with a pending request
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_data_a", rsp_data_a, 32'd0);
    end
    chk("rst_data_b", rsp_data_b, 32'd0);
    rst       = 1'b1;
    req_valid = 1'b0;
    step();
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // 2: basic read
    req_addr_a = 5'd5;
    req_addr_b = 5'd9;
    req_valid  = 1'b1;
    rsp_ready  = 1'b1;
    step();
    req_valid = 1'b0;
    chk("basic_valid", {31'd0, rsp_valid}, 32'd1);
    chk("basic_a", rsp_data_a, 32'hDEAD_BEEF);
    chk("basic_b", rsp_data_b, 32'h1234_5678);
    chk("basic_err", {31'd0, rsp_err}, 32'd0);
    step();

    // 3: zero register beats bypass, bypass on reg 7
    req_addr_a = 5'd0;
    req_addr_b = 5'd7;
    wr_en      = 32'h0000_0081;
    wr_d       = 32'hCAFE_0001;
    req_valid  = 1'b1;
    step();
    req_valid = 1'b0;
    wr_en     = '0;
    chk("zero_a", rsp_data_a, 32'd0);
    chk("bypass_b", rsp_data_b, 32'hCAFE_0001);
    step();

    // 4: backpressure fills OUT and SKID, later write must not leak in
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_addr_a = 5'd1;
    req_addr_b = 5'd0;
    step();
    req_addr_a = 5'd2;
    step();
    req_valid = 1'b0;
    chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
    chk("bp_first_a", rsp_data_a, 32'h0101_0101);
    wr_en = 32'h0000_0002;
    wr_d  = 32'hFFFF_FFFF;
    step();
    wr_en = '0;
    chk("bp_held_a", rsp_data_a, 32'h0101_0101);
    rsp_ready = 1'b1;
    step();
    chk("bp_second_a", rsp_data_a, 32'h0202_0202);
    chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
    step();
    chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

    // 5: streaming, one response per cycle
    req_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      req_addr_a = 5'(k);
      req_addr_b = 5'(15 - k);
      step();
      chk("stream_valid", {31'd0, rsp_valid}, 32'd1);
    end
    req_valid = 1'b0;
    step();
    step();

    // 6: reset while both registers are occupied
    rsp_ready  = 1'b0;
    req_valid  = 1'b1;
    req_addr_a = 5'd3;
    step();
    req_addr_a = 5'd4;
    step();
    req_valid = 1'b0;
    chk("mid_both", {31'd0, req_ready}, 32'd0);
    rst = 1'b0;
    step();
    chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    rst        = 1'b1;
    rsp_ready  = 1'b1;
    req_valid  = 1'b1;
    req_addr_a = 5'd6;
    req_addr_b = 5'd0;
    step();
    req_valid = 1'b0;
    chk("after_rst_valid", {31'd0, rsp_valid}, 32'd1);
    chk("after_rst_a", rsp_data_a, 32'h0606_0606);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_reg_bank_reader
